// File: rtl/shift_concat.sv
// Packs variable-length codes (0-64 bits, MSB-first) into 64-bit words,
// with a flush path that drains a partial word zero-padded.
module shift_concat (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] comp_data,
   input  logic [6:0]  valid_bits,
   input  logic        comp_valid,
   input  logic        flush,
   input  logic        stall,
   output logic [63:0] data_out,
   output logic        scon_done,
   output logic [6:0]  pad_bits,
   output logic [6:0]  fill,
   output logic        len_err
);

   localparam int unsigned W  = 64;
   localparam int unsigned BW = 128;
   localparam int unsigned CW = 7;
   localparam int unsigned SW = 8;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FLUSH = 2'd1
   } state_t;

   state_t          state, state_n;
   logic [BW-1:0]   buf_q, buf_n;
   logic [CW-1:0]   fill_n, pad_n;
   logic [W-1:0]    data_n;
   logic            done_n, err_n;

   logic            accept;
   logic [W-1:0]    masked;
   logic [BW-1:0]   aligned;
   logic [BW-1:0]   merged;
   logic [SW-1:0]   sum;

   // Buffer holds valid bits at the top (earliest at bit 127); bits below fill are always zero.
   always_comb begin
      accept  = comp_valid && (valid_bits <= CW'(W));
      masked  = (valid_bits >= CW'(W)) ? comp_data
                                       : comp_data & ((W'(1) << valid_bits) - W'(1));
      aligned = BW'(masked) << (SW'(BW) - SW'(valid_bits));
      merged  = accept ? (buf_q | (aligned >> fill)) : buf_q;
      sum     = SW'(fill) + (accept ? SW'(valid_bits) : SW'(0));
   end

   // Next-state and output logic
   always_comb begin
      state_n = state;
      buf_n   = buf_q;
      fill_n  = fill;
      data_n  = data_out;
      pad_n   = pad_bits;
      done_n  = 1'b0;
      err_n   = len_err;
      if (!stall) begin
         case (state)
            ACCUM: begin
               if (comp_valid && !accept)
                  err_n = 1'b1;
               if (sum >= SW'(W)) begin
                  data_n = merged[BW-1:W];
                  buf_n  = merged << W;
                  fill_n = CW'(sum - SW'(W));
                  pad_n  = '0;
                  done_n = 1'b1;
                  if (flush)
                     state_n = FLUSH;
               end else if (flush && (sum != '0)) begin
                  data_n = merged[BW-1:W];
                  buf_n  = '0;
                  fill_n = '0;
                  pad_n  = CW'(SW'(W) - sum);
                  done_n = 1'b1;
               end else begin
                  buf_n  = merged;
                  fill_n = CW'(sum);
               end
            end
            FLUSH: begin
               // Incoming codes are dropped here; upstream is held off by control.
               if (fill != '0) begin
                  data_n = buf_q[BW-1:W];
                  buf_n  = '0;
                  fill_n = '0;
                  pad_n  = CW'(W) - fill;
                  done_n = 1'b1;
               end
               state_n = ACCUM;
            end
            default: state_n = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ACCUM;
         buf_q     <= '0;
         fill      <= '0;
         data_out  <= '0;
         pad_bits  <= '0;
         scon_done <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         state     <= state_n;
         buf_q     <= buf_n;
         fill      <= fill_n;
         data_out  <= data_n;
         pad_bits  <= pad_n;
         scon_done <= done_n;
         len_err   <= err_n;
      end
   end

endmodule

// File: tb/tb_shift_concat.sv
// Bench for shift_concat: bit-queue reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_shift_concat;

   logic        clk;
   logic        rst;
   logic [63:0] comp_data;
   logic [6:0]  valid_bits;
   logic        comp_valid;
   logic        flush;
   logic        stall;
   logic [63:0] data_out;
   logic        scon_done;
   logic [6:0]  pad_bits;
   logic [6:0]  fill;
   logic        len_err;

   shift_concat dut (
      .clk        (clk),
      .rst        (rst),
      .comp_data  (comp_data),
      .valid_bits (valid_bits),
      .comp_valid (comp_valid),
      .flush      (flush),
      .stall      (stall),
      .data_out   (data_out),
      .scon_done  (scon_done),
      .pad_bits   (pad_bits),
      .fill       (fill),
      .len_err    (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Reference model: a plain bit queue, earliest bit at the front.
   bit          q[$];
   logic [63:0] exp_data = '0;
   logic        exp_done = 1'b0;
   int          exp_pad  = 0;
   logic        exp_err  = 1'b0;
   bit          pend     = 1'b0;

   task automatic model_emit();
      logic [63:0] word;
      int n;
      word = '0;
      n = q.size();
      for (int i = 0; i < 64; i++)
         if (q.size() > 0) word[63-i] = q.pop_front();
      exp_data = word;
      exp_pad  = (n >= 64) ? 0 : 64 - n;
      exp_done = 1'b1;
   endtask

   always @(posedge clk) begin
      exp_done = 1'b0;
      if (!rst) begin
         q.delete();
         exp_data = '0;
         exp_pad  = 0;
         exp_err  = 1'b0;
         pend     = 1'b0;
      end else if (!stall) begin
         if (pend) begin
            pend = 1'b0;
            if (q.size() > 0) model_emit();
         end else begin
            if (comp_valid) begin
               if (valid_bits > 7'd64) exp_err = 1'b1;
               else
                  for (int i = int'(valid_bits) - 1; i >= 0; i--) q.push_back(comp_data[i]);
            end
            if (q.size() >= 64) begin
               model_emit();
               if (flush) pend = 1'b1;
            end else if (flush && q.size() > 0) begin
               model_emit();
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check("model.data_out",  data_out,        exp_data);
         check("model.scon_done", 64'(scon_done),  64'(exp_done));
         check("model.pad_bits",  64'(pad_bits),   64'(exp_pad));
         check("model.fill",      64'(fill),       64'(q.size()));
         check("model.len_err",   64'(len_err),    64'(exp_err));
      end
   end

   task automatic step(input logic [63:0] d, input int vb, input logic cv,
                       input logic fl, input logic st);
      comp_data  = d;
      valid_bits = 7'(vb);
      comp_valid = cv;
      flush      = fl;
      stall      = st;
      @(negedge clk);
   endtask

   localparam logic [63:0] WA = 64'h0123456789ABCDEF;
   localparam logic [63:0] WB = 64'hFEDCBA9876543210;
   localparam logic [63:0] WC = 64'h8000000000000001;

   initial begin
      logic [63:0] words [3];
      words[0] = WA; words[1] = WB; words[2] = WC;
      rst = 1'b0;
      comp_data = '0; valid_bits = '0; comp_valid = 1'b0; flush = 1'b0; stall = 1'b0;

      // Reset
      step('0, 0, 0, 0, 0);
      checking = 1'b1;
      step('0, 0, 0, 0, 0);
      check("rst.data_out", data_out, 64'h0);
      check("rst.fill", 64'(fill), 64'd0);
      check("rst.done", 64'(scon_done), 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step('0, 0, 1, 0, 0);
      check("zero_len.fill", 64'(fill), 64'd0);
      check("zero_len.done", 64'(scon_done), 64'd0);

      // Packing across a word boundary; garbage above valid_bits must be ignored
      step(64'h00000000_00AAAAAA, 24, 1, 0, 0);
      step(64'hFFFFFFFF_FF555555, 24, 1, 0, 0);
      step(64'h00000000_00FFFFFF, 24, 1, 0, 0);
      check("pack.done", 64'(scon_done), 64'd1);
      check("pack.data_out", data_out, 64'hAAAAAA555555FFFF);
      check("pack.fill3", 64'(fill), 64'd8);
      step(64'hDEADBEEF_DE000000, 24, 1, 0, 0);
      check("pack.fill4", 64'(fill), 64'd32);
      step('0, 0, 0, 1, 0);
      check("pack.flush_data", data_out, 64'hFF00000000000000);
      check("pack.flush_pad", 64'(pad_bits), 64'd32);

      // Full-width stream
      for (int i = 0; i < 3; i++) begin
         step(words[i], 64, 1, 0, 0);
         check("full.data_out", data_out, words[i]);
         check("full.done", 64'(scon_done), 64'd1);
         check("full.fill", 64'(fill), 64'd0);
      end
      step('0, 0, 0, 0, 0);

      // Flush of a 20-bit partial word
      step(64'h00000000_000ABCDE, 20, 1, 0, 0);
      step('0, 0, 0, 1, 0);
      check("flush20.data_out", data_out, 64'hABCDE00000000000);
      check("flush20.pad", 64'(pad_bits), 64'd44);
      check("flush20.fill", 64'(fill), 64'd0);

      // Flush crossing a word: 40 + 30 bits
      step(64'h00000012_3456789A, 40, 1, 0, 0);
      step(64'h00000000_15555555, 30, 1, 1, 0);
      check("flush70.word", data_out, 64'h123456789A555555);
      check("flush70.pad0", 64'(pad_bits), 64'd0);
      step('0, 0, 1, 0, 0);
      check("flush70.rem", data_out, 64'h5400000000000000);
      check("flush70.pad", 64'(pad_bits), 64'd58);
      check("flush70.done", 64'(scon_done), 64'd1);
      check("flush70.fill", 64'(fill), 64'd0);

      // Stall mid-word, then an illegal length
      step(64'h00000000_0000BEEF, 16, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(WA, 64, 1, 1, 1);
         check("stall.fill", 64'(fill), 64'd16);
         check("stall.done", 64'(scon_done), 64'd0);
      end
      step(WB, 65, 1, 0, 0);
      check("len_err.set", 64'(len_err), 64'd1);
      check("len_err.fill", 64'(fill), 64'd16);
      step('0, 0, 0, 0, 0);
      step('0, 0, 0, 0, 0);
      check("len_err.sticky", 64'(len_err), 64'd1);

      // Reset mid-word
      step(64'h00000003_00000001, 34, 1, 0, 0);
      check("mid.fill50", 64'(fill), 64'd50);
      rst = 1'b0;
      step('0, 0, 0, 0, 0);
      rst = 1'b1;
      check("mid.fill0", 64'(fill), 64'd0);
      check("mid.len_err", 64'(len_err), 64'd0);
      step(WA, 64, 1, 0, 0);
      check("mid.clean_word", data_out, WA);
      check("mid.done", 64'(scon_done), 64'd1);
      step('0, 0, 0, 0, 0);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
